// File: rtl/vga_pkg.sv
// Shared types and defaults for the per-frame update scheduler.
// Slot indices name the requesters serviced during vertical blanking.
package vga_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        NEXT,
        DONE
    } sched_state_t;

    localparam int NUM_SLOTS_DEF = 3;
    localparam int TIMEOUT_DEF   = 255;

    localparam logic [1:0] SLOT_PADDLE = 2'd0;
    localparam logic [1:0] SLOT_BALL   = 2'd1;
    localparam logic [1:0] SLOT_SCORE  = 2'd2;

endpackage

// File: rtl/edge_detect.sv
// Registered falling-edge detector: fall pulses one cycle after
// the first clock that samples din low following a high sample.
module edge_detect (
    input  logic clck,
    input  logic reset_n,
    input  logic din,
    output logic fall
);

    logic din_q;

    always_ff @(posedge clck) begin
        if (!reset_n) begin
            din_q <= 1'b0;
            fall  <= 1'b0;
        end else begin
            din_q <= din;
            fall  <= din_q & ~din;
        end
    end

endmodule

// File: rtl/update_scheduler.sv
// Walks the enabled update slots once per vertical blanking, issuing
// a start pulse to each and waiting for its done or a timeout.
module update_scheduler
    import vga_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                 clck,
    input  logic                 reset_n,
    input  logic                 activeLine,
    input  logic [NUM_SLOTS-1:0] slot_en,
    input  logic [NUM_SLOTS-1:0] upd_done,
    input  logic                 clr_err,
    output logic [NUM_SLOTS-1:0] upd_start,
    output logic                 busy,
    output logic [1:0]           cur_slot,
    output logic                 overrun,
    output logic                 timeout_err,
    output logic [7:0]           frame_count
);

    localparam int PW = $clog2(NUM_SLOTS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    sched_state_t         state, state_n;
    logic [NUM_SLOTS-1:0] en_q, en_n;
    logic [PW-1:0]        ptr, ptr_n;
    logic [TW-1:0]        timer, timer_n;
    logic [1:0]           slot_n;
    logic [7:0]           fc_n;
    logic                 ovr_set, tmo_set;
    logic                 blank_start;
    logic                 found;
    logic [1:0]           pick;

    edge_detect u_edge (
        .clck    (clck),
        .reset_n (reset_n),
        .din     (activeLine),
        .fall    (blank_start)
    );

    // Lowest enabled slot at or above the search pointer.
    always_comb begin
        found = 1'b0;
        pick  = SLOT_PADDLE;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (en_q[i] && i >= int'(ptr)) begin
                found = 1'b1;
                pick  = i[1:0];
            end
        end
    end

    always_comb begin
        state_n = state;
        en_n    = en_q;
        ptr_n   = ptr;
        timer_n = timer;
        slot_n  = cur_slot;
        fc_n    = frame_count;
        ovr_set = 1'b0;
        tmo_set = 1'b0;

        unique case (state)
            IDLE: begin
                if (blank_start) begin
                    en_n    = slot_en;
                    ptr_n   = PW'(SLOT_PADDLE);
                    state_n = NEXT;
                end
            end
            NEXT: begin
                if (found) begin
                    slot_n  = pick;
                    state_n = START;
                end else begin
                    state_n = DONE;
                end
            end
            START: begin
                timer_n = '0;
                state_n = WAIT;
            end
            WAIT: begin
                if (upd_done[cur_slot]) begin
                    ptr_n   = PW'(cur_slot) + 1'b1;
                    state_n = NEXT;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    tmo_set = 1'b1;
                    ptr_n   = PW'(cur_slot) + 1'b1;
                    state_n = NEXT;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            DONE: begin
                fc_n    = frame_count + 8'd1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Visible video resumed mid-sequence: drop everything else.
        if (activeLine && state != IDLE && state != DONE) begin
            state_n = IDLE;
            ovr_set = 1'b1;
            tmo_set = 1'b0;
        end
    end

    always_ff @(posedge clck) begin
        if (!reset_n) begin
            state       <= IDLE;
            en_q        <= '0;
            ptr         <= '0;
            timer       <= '0;
            cur_slot    <= 2'd0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            state       <= state_n;
            en_q        <= en_n;
            ptr         <= ptr_n;
            timer       <= timer_n;
            cur_slot    <= slot_n;
            overrun     <= ovr_set | (overrun & ~clr_err);
            timeout_err <= tmo_set | (timeout_err & ~clr_err);
            frame_count <= fc_n;
        end
    end

    assign busy = (state != IDLE);

    always_comb begin
        upd_start = '0;
        if (state == START) begin
            upd_start[cur_slot] = 1'b1;
        end
    end

endmodule

// File: doc/update_scheduler.md
UPDATE_SCHEDULER -- requirements
Module: update_scheduler

Interface
REQ-001 Parameter NUM_SLOTS, default 3, number of update requesters; slot 0 = paddle, 1 = ball, 2 = spare/score.
REQ-002 Parameter TIMEOUT, default 255, maximum WAIT cycles per slot before forced advance.
REQ-003 clck  in  1  single system clock; all logic on posedge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 activeLine  in  1  high during visible lines, from the vsync controller.
REQ-006 slot_en  in  NUM_SLOTS  per-slot enable, sampled at blanking start.
REQ-007 upd_done  in  NUM_SLOTS  per-slot completion pulse/level from requester.
REQ-008 clr_err  in  1  clears sticky overrun and timeout_err.
REQ-009 upd_start  out  NUM_SLOTS  one-cycle start pulse to the selected slot.
REQ-010 busy  out  1  high while a frame update sequence is in progress.
REQ-011 cur_slot  out  2  index of slot currently started/awaited.
REQ-012 overrun  out  1  sticky; blanking ended before sequence finished.
REQ-013 timeout_err  out  1  sticky; some slot hit TIMEOUT.
REQ-014 frame_count  out  8  count of completed update sequences.

Function
REQ-015 Blanking-start event SHALL be registered falling edge of activeLine: al_q & ~activeLine, al_q = activeLine delayed one clck.
REQ-016 States SHALL be IDLE, START, WAIT, NEXT, DONE.
REQ-017 IDLE: on blanking-start, latch slot_en into en_q; go to NEXT with cur_slot search starting at index 0.
REQ-018 NEXT: select lowest enabled index >= search pointer → START; none left → DONE; disabled slots never started.
REQ-019 START: upd_start[cur_slot] = 1 for exactly this one cycle, all other bits 0; clear wait timer; go to WAIT.
REQ-020 WAIT: upd_done[cur_slot] high → NEXT with search pointer cur_slot+1; upd_done of other slots ignored.
REQ-021 WAIT: timer reaches TIMEOUT-1 without done → set timeout_err, go to NEXT with pointer cur_slot+1.
REQ-022 DONE: frame_count increments by 1 (wraps 255→0); go to IDLE.
REQ-023 Latency: first upd_start SHALL appear 3 clck after the cycle activeLine is first sampled low (edge reg, NEXT, START).
REQ-024 Abort: activeLine high in any state other than IDLE/DONE → overrun set, state → IDLE, no further starts, frame_count unchanged.
REQ-025 Done and abort same cycle: abort wins; no further start issued.
REQ-026 All slot_en zero at blanking start: no starts, DONE reached, frame_count increments.
REQ-027 clr_err same cycle as a set event: set wins.
REQ-028 busy SHALL equal (state != IDLE); outputs decoded from registers only, no input-to-output combinational path.
REQ-029 Blanking-start events while busy SHALL be ignored.

Reset
REQ-030 While reset_n low at posedge: state IDLE, upd_start 0, busy 0, cur_slot 0, overrun 0, timeout_err 0, frame_count 0, al_q 0, timer 0.
REQ-031 Reset asserted mid-sequence SHALL abandon it with no further upd_start and no flag set.

Structure
REQ-032 Shared package vga_pkg SHALL hold the state enum type, NUM_SLOTS and TIMEOUT defaults, and slot index constants.
REQ-033 One sub-module, edge_detect (registered falling-edge detector), SHALL be instantiated for activeLine; all else flat.

Verification
REQ-034 activeLine 1→0, slot_en=3'b011, done 2 cycles after each start → upd_start[0] at edge+3, then [1], frame_count 0→1, busy low after DONE.
REQ-035 slot_en=3'b101 → only upd_start[0] and [2] pulse; upd_start[1] never asserted.
REQ-036 slot 1 never returns done, TIMEOUT=255 → timeout_err set 255 cycles after upd_start[1], slot 2 started next cycle+1.
REQ-037 activeLine rises while in WAIT on slot 0 → overrun=1, busy=0 next cycle, frame_count unchanged, no upd_start[1]; clr_err pulse → overrun=0.
REQ-038 frame_count=255, complete one sequence → frame_count=0.
REQ-039 reset_n low during WAIT → all outputs zero next cycle; next blanking edge restarts at slot 0.
